// File: rtl/snd_vramarb_if.sv
// snd_vramarb_if: bundle between the two VRAM requesters, the VRAM read port and the arbiter
// slave  : arbiter side (takes req/adr/vif inputs, drives VRAM request, acks, steered valids, status)
// master : environment side (requesters plus VRAM interface)
interface snd_vramarb_if #(parameter int ADR_W = 23);
  logic             req0, req1;
  logic [ADR_W-1:0] adr0, adr1;
  logic             vif_sndack, vif_sndrdatavld;
  logic             snd_vramreq;
  logic [ADR_W-1:0] snd_vramadr;
  logic             ack0, ack1, rdvld0, rdvld1;
  logic             busy, err_tmo, err_stray;
  modport slave (
    input  req0, req1, adr0, adr1, vif_sndack, vif_sndrdatavld,
    output snd_vramreq, snd_vramadr, ack0, ack1, rdvld0, rdvld1, busy, err_tmo, err_stray
  );
  modport master (
    output req0, req1, adr0, adr1, vif_sndack, vif_sndrdatavld,
    input  snd_vramreq, snd_vramadr, ack0, ack1, rdvld0, rdvld1, busy, err_tmo, err_stray
  );
endinterface

// File: rtl/snd_vramarb.sv
// snd_vramarb: round-robin arbiter of the sound VRAM read port between playback (0) and effect (1) fetch
// clk/rst  : clock, asynchronous active-high reset
// bus      : req0/1+adr0/1 in, vif_sndack/vif_sndrdatavld in, snd_vramreq/adr, ack0/1, rdvld0/1,
//            busy, err_tmo, err_stray out
module snd_vramarb #(
  parameter int BURST_LEN = 4,
  parameter int ADR_W     = 23,
  parameter int TMO_CYC   = 255
) (
  input logic           clk,
  input logic           rst,
  snd_vramarb_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;
  localparam logic [3:0] BL = 4'(BURST_LEN);
  localparam logic [7:0] TM = 8'(TMO_CYC);
  state_t           state_q, state_d;
  logic             owner_q, owner_d, last_grant_q, last_grant_d, req_q, req_d;
  logic             ack0_q, ack0_d, ack1_q, ack1_d, err_tmo_q, err_tmo_d, err_stray_q, err_stray_d;
  logic [3:0]       beat_cnt_q, beat_cnt_d;
  logic [7:0]       tmo_cnt_q, tmo_cnt_d;
  logic [ADR_W-1:0] adr_q, adr_d;
  logic             steer, winner, vld;
  assign vld    = bus.vif_sndrdatavld;
  // a beat arriving with the ack already belongs to the burst
  assign steer  = state_q == DATA || (state_q == REQ && bus.vif_sndack);
  assign winner = bus.req0 & bus.req1 ? ~last_grant_q : bus.req1;
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    req_d        = req_q;
    adr_d        = adr_q;
    beat_cnt_d   = beat_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    err_tmo_d    = err_tmo_q;
    err_stray_d  = err_stray_q | (vld & ~steer);
    case (state_q)
      IDLE: if (bus.req0 | bus.req1) begin
        owner_d = winner;
        adr_d   = winner ? bus.adr1 : bus.adr0;
        req_d   = 1'b1;
        state_d = REQ;
      end
      REQ: if (bus.vif_sndack) begin
        req_d        = 1'b0;
        ack0_d       = ~owner_q;
        ack1_d       = owner_q;
        last_grant_d = owner_q;
        beat_cnt_d   = {3'b000, vld};
        tmo_cnt_d    = 8'd0;
        state_d      = beat_cnt_d == BL ? IDLE : DATA;
      end
      DATA: if (vld) begin
        beat_cnt_d = beat_cnt_q + 4'd1;
        tmo_cnt_d  = 8'd0;
        state_d    = beat_cnt_d == BL ? IDLE : DATA;
      end else begin
        tmo_cnt_d = tmo_cnt_q + 8'd1;
        err_tmo_d = err_tmo_q | (tmo_cnt_d == TM);
        state_d   = tmo_cnt_d == TM ? IDLE : DATA;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      req_q        <= 1'b0;
      adr_q        <= '0;
      beat_cnt_q   <= 4'd0;
      tmo_cnt_q    <= 8'd0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      err_tmo_q    <= 1'b0;
      err_stray_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      req_q        <= req_d;
      adr_q        <= adr_d;
      beat_cnt_q   <= beat_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      err_tmo_q    <= err_tmo_d;
      err_stray_q  <= err_stray_d;
    end
  assign bus.snd_vramreq = req_q;
  assign bus.snd_vramadr = adr_q;
  assign bus.ack0        = ack0_q;
  assign bus.ack1        = ack1_q;
  assign bus.rdvld0      = steer & vld & ~owner_q;
  assign bus.rdvld1      = steer & vld & owner_q;
  assign bus.busy        = state_q != IDLE;
  assign bus.err_tmo     = err_tmo_q;
  assign bus.err_stray   = err_stray_q;
endmodule

// File: tb/tb_snd_vramarb.sv
// tb_snd_vramarb: randomized check of snd_vramarb against a burst-level reference model
module tb_snd_vramarb;
  localparam int BL = 4, AW = 23, TMO = 12, NCYC = 20000;
  logic clk = 1'b0, rst = 1'b1;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  snd_vramarb_if #(.ADR_W(AW)) bus();
  snd_vramarb #(.BURST_LEN(BL), .ADR_W(AW), .TMO_CYC(TMO)) dut (.clk(clk), .rst(rst), .bus(bus));
  // reference model: burst phase, who holds it, how far along it is
  int          m_ph;
  int          m_owner, m_pref, m_beats, m_quiet;
  logic        m_vreq, m_etmo, m_estr;
  logic [AW-1:0] m_adr;
  logic        m_ack [2];
  int          n_bursts = 0, n_tmo = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      if (failures <= 30) $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_ph = 0; m_owner = 0; m_pref = 0; m_beats = 0; m_quiet = 0;
    m_vreq = 0; m_adr = '0; m_etmo = 0; m_estr = 0; m_ack[0] = 0; m_ack[1] = 0;
  endtask
  function automatic logic steered();
    return bus.vif_sndrdatavld && (m_ph == 2 || (m_ph == 1 && bus.vif_sndack));
  endfunction
  task automatic model_step();
    logic v;
    v = bus.vif_sndrdatavld;
    if (v && !steered()) m_estr = 1;
    m_ack[0] = 0; m_ack[1] = 0;
    if (m_ph == 0) begin
      if (bus.req0 || bus.req1) begin
        m_owner = (bus.req0 && bus.req1) ? m_pref : (bus.req1 ? 1 : 0);
        m_adr   = m_owner == 1 ? bus.adr1 : bus.adr0;
        m_vreq  = 1; m_ph = 1;
      end
    end else if (m_ph == 1) begin
      if (bus.vif_sndack) begin
        m_vreq = 0; m_ack[m_owner] = 1; m_pref = 1 - m_owner;
        m_beats = v ? 1 : 0; m_quiet = 0; n_bursts++;
        m_ph = m_beats == BL ? 0 : 2;
      end
    end else if (v) begin
      m_beats++; m_quiet = 0;
      if (m_beats == BL) m_ph = 0;
    end else begin
      m_quiet++;
      if (m_quiet == TMO) begin m_etmo = 1; m_ph = 0; n_tmo++; end
    end
  endtask
  task automatic chk_regs();
    check("snd_vramreq", 32'(bus.snd_vramreq), 32'(m_vreq));
    check("snd_vramadr", 32'(bus.snd_vramadr), 32'(m_adr));
    check("ack0", 32'(bus.ack0), 32'(m_ack[0]));
    check("ack1", 32'(bus.ack1), 32'(m_ack[1]));
    check("busy", 32'(bus.busy), 32'(m_ph != 0));
    check("err_tmo", 32'(bus.err_tmo), 32'(m_etmo));
    check("err_stray", 32'(bus.err_stray), 32'(m_estr));
  endtask
  initial begin
    int pct;
    logic s;
    bus.req0 = 0; bus.req1 = 0; bus.adr0 = '0; bus.adr1 = '0;
    bus.vif_sndack = 0; bus.vif_sndrdatavld = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk_regs();
    check("rdvld0_rst", 32'(bus.rdvld0), 32'd0);
    check("rdvld1_rst", 32'(bus.rdvld1), 32'd0);
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      chk_regs();
      if (rst) rst = 1'b0;
      else if ($urandom_range(2999) == 0) begin
        rst = 1'b1;
        #1;
        model_reset();
        chk_regs();
        continue;
      end
      if (m_ack[0] && $urandom_range(7) != 0) bus.req0 = 0;
      else if (!bus.req0 && $urandom_range(3) == 0) begin bus.req0 = 1; bus.adr0 = AW'($urandom); end
      else if (bus.req0 && m_ph == 1 && m_owner == 0 && $urandom_range(63) == 0) bus.req0 = 0;
      if (m_ack[1] && $urandom_range(7) != 0) bus.req1 = 0;
      else if (!bus.req1 && $urandom_range(3) == 0) begin bus.req1 = 1; bus.adr1 = AW'($urandom); end
      else if (bus.req1 && m_ph == 1 && m_owner == 1 && $urandom_range(63) == 0) bus.req1 = 0;
      bus.vif_sndack = $urandom_range(2) == 0;
      case ((cyc >> 5) & 3)
        0, 1:    pct = 50;
        2:       pct = 10;
        default: pct = 0;
      endcase
      if (m_ph == 2 || (m_ph == 1 && bus.vif_sndack)) bus.vif_sndrdatavld = $urandom_range(99) < pct;
      else bus.vif_sndrdatavld = $urandom_range(199) == 0;
      #1;
      s = steered();
      check("rdvld0", 32'(bus.rdvld0), 32'(s && m_owner == 0));
      check("rdvld1", 32'(bus.rdvld1), 32'(s && m_owner == 1));
      @(posedge clk);
      model_step();
    end
    check("bursts_seen", 32'(n_bursts > 100), 32'd1);
    check("timeouts_seen", 32'(n_tmo > 5), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
